// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parameterised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register, saturating fill count and masked pattern compare.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  localparam int LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               bit_in,
  input  logic               overlap,
  input  logic [LW-1:0]      len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill;
  logic [LW-1:0]      fill_inc;

  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], bit_in};
    fill_inc = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len));
    // Fill includes the bit being shifted in this cycle.
    hit = shift && (fill_inc >= len) &&
          (((hist_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      fill <= (hit && !overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Configurable serial pattern detector: config FSM, match pulse and
// saturating match counter around the shift/compare window.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 8,
  localparam int LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr,
  output logic               armed,
  output logic               cfg_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic               len_ok;
  logic               shift;
  logic               hit;

  assign len_ok = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));
  // A load in the same cycle drops the incoming bit.
  assign shift  = in_valid && (state == ARMED) && !cfg_load;
  assign armed  = (state == ARMED);

  seq_det_window #(
    .MAX_LEN (MAX_LEN)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .clr     (cfg_load),
    .shift   (shift),
    .bit_in  (in_bit),
    .overlap (ovl_q),
    .len     (len_q),
    .pattern (pat_q),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      match     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        if (!len_ok) begin
          state   <= IDLE;
          cfg_err <= 1'b1;
        end else begin
          state <= en ? ARMED : PAUSED;
        end
      end else begin
        unique case (state)
          ARMED:   if (!en) state <= PAUSED;
          PAUSED:  if (en)  state <= ARMED;
          default: state <= IDLE;
        endcase
      end
      if (cnt_clr)
        match_cnt <= '0;
      else if (hit && match_cnt != CNT_MAX)
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, meaning the longest detectable pattern in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  run enable; low pauses detection and retains history.
REQ-006 The block SHALL have port cfg_load  input  1  load strobe for the pattern, length and mode.
REQ-007 The block SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 is the last.
REQ-008 The block SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits.
REQ-009 The block SHALL have port cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping matches.
REQ-010 The block SHALL have port in_valid  input  1  qualifies in_bit.
REQ-011 The block SHALL have port in_bit  input  1  serial data bit.
REQ-012 The block SHALL have port match  output  1  registered one-cycle match pulse.
REQ-013 The block SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-014 The block SHALL have port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-015 The block SHALL have port armed  output  1  high while the FSM is in ARMED.
REQ-016 The block SHALL have port cfg_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-017 The FSM SHALL have the states IDLE (no valid config), ARMED (detecting) and PAUSED (config held, bits ignored).
REQ-018 On cfg_load, in any state, the block SHALL capture pattern, length and mode, and SHALL clear the history and the fill count.
- The next state SHALL be ARMED if 2<=cfg_len<=MAX_LEN and en=1; PAUSED if the length is legal and en=0.
- Otherwise the next state SHALL be IDLE, with cfg_err=1 for the next cycle.
REQ-019 cfg_load SHALL take priority over a simultaneous in_valid; that bit SHALL be dropped.
REQ-020 A low en SHALL move ARMED to PAUSED; a high en SHALL move PAUSED to ARMED; history and fill SHALL be retained across the pause.
REQ-021 The block SHALL accept in_bit only when in_valid=1, the state is ARMED and cfg_load=0; when accepted, the bit SHALL shift into a MAX_LEN history and fill SHALL increment, saturating at MAX_LEN.
REQ-022 A match SHALL occur on an accepted bit when fill (including this bit) >= len and the newest len history bits equal cfg_pattern[len-1:0].
REQ-023 match SHALL go high in the cycle after the completing bit is accepted (latency 1), for exactly one cycle per match.
REQ-024 Fill after a match SHALL depend on the mode.
- Overlap: fill SHALL be kept, so trailing bits can begin the next match.
- Non-overlap: fill SHALL be cleared to 0, so the completing bit is not reused.
REQ-025 match_cnt SHALL increment on each match and saturate at 2^CNT_W-1.
- cnt_clr SHALL set it to 0.
- cnt_clr together with a match SHALL result in 0.
REQ-026 No match SHALL be produced in IDLE or PAUSED.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set the state to IDLE; history, fill, stored config, match, match_cnt and cfg_err to 0; and armed to 0.
REQ-028 rst SHALL take priority over cfg_load, cnt_clr and in_valid; a reset mid-pattern SHALL discard all partial progress.

Structure
REQ-029 The shared package seq_det_pkg SHALL hold the state enum (IDLE/ARMED/PAUSED) and the length-width helper constant.
REQ-030 The history shift register, fill counter and masked compare SHALL be one sub-module, seq_det_window; the FSM and counter SHALL stay at the top level.

Verification
REQ-031 Reset, load 5'b10010/len5/non-overlap, stream 1001010010 -> match pulses one cycle after bits 5 and 10; match_cnt=2.
REQ-032 Load 3'b101/len3/overlap, stream 10101 -> matches after bits 3 and 5; repeat with non-overlap -> only the bit-3 match; match_cnt=1.
REQ-033 cfg_len=1, then cfg_len=0 -> cfg_err pulse each time, armed=0, no match on any stream.
REQ-034 Pattern 10010, stream 100, en=0 with bits 11, en=1, stream 10 -> a single match; the paused bits are ignored.
REQ-035 CNT_W=2, five matches -> match_cnt=3 (saturated); cnt_clr in the same cycle as a match -> match_cnt=0.
REQ-036 rst asserted after 1001 of 10010, then a new load and 10010 -> no match before 5 fresh bits, then a match; match_cnt=1.
